multiword_add_ctrl: RTL and testbench



---
 rtl/multiword_add_ctrl.sv | 139 +++++++++++++
 tb/tb_multiword_add_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// Multi-cycle wide adder: one BIT_WIDTH full_adder slice reused over NUM_WORDS cycles,
// least-significant slice first, carry chained through a register between cycles.

module full_adder #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};
endmodule

module multiword_add_ctrl #(
    parameter int BIT_WIDTH     = 4,
    parameter int OPERAND_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_a,
    input  logic [OPERAND_WIDTH-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);
    localparam int NUM_WORDS = OPERAND_WIDTH / BIT_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    generate
        if (BIT_WIDTH < 1 || OPERAND_WIDTH < BIT_WIDTH ||
            (NUM_WORDS * BIT_WIDTH) != OPERAND_WIDTH) begin : g_bad_params
            $error("OPERAND_WIDTH must be a non-zero multiple of BIT_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic                     carry;
    logic [OPERAND_WIDTH-1:0] opa;
    logic [OPERAND_WIDTH-1:0] opb;
    logic [BIT_WIDTH-1:0]     fa_a;
    logic [BIT_WIDTH-1:0]     fa_b;
    logic [BIT_WIDTH-1:0]     fa_sum;
    logic                     fa_cout;
    logic                     accept;
    logic                     last;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);
    assign fa_a   = opa[idx*BIT_WIDTH +: BIT_WIDTH];
    assign fa_b   = opb[idx*BIT_WIDTH +: BIT_WIDTH];

    full_adder #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_fa (
        .a   (fa_a),
        .b   (fa_b),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operands are pure data: captured on accept only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa <= in_a;
            opb <= in_b;
        end
    end

    // Slice results land directly in out_sum; it is only meaningful once DONE is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    out_sum[idx*BIT_WIDTH +: BIT_WIDTH] <= fa_sum;
                    carry <= fa_cout;
                    if (last) begin
                        idx      <= '0;
                        out_cout <= fa_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl: directed vector table, hand-written corner sequences and
// randomized transactions on a 16/4 instance and an 8/8 (single-slice) instance.

module tb_multiword_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid0, in_ready0, in_cin0, out_valid0, out_ready0, out_cout0, busy0;
    logic [15:0] a0, b0, out_sum0;
    logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
    logic [7:0]  a1, b1, out_sum1;

    multiword_add_ctrl #(.BIT_WIDTH(4), .OPERAND_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(a0), .in_b(b0), .in_cin(in_cin0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_sum(out_sum0), .out_cout(out_cout0), .busy(busy0)
    );

    multiword_add_ctrl #(.BIT_WIDTH(8), .OPERAND_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(a1), .in_b(b1), .in_cin(in_cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        int          stall;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out", name);
    endtask

    // One transaction on dut0; result is taken at the first cycle out_valid is seen.
    task automatic txn0(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int stall, output logic [15:0] s, output logic co,
                        output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready0 && w < 50) begin @(negedge clk); w++; end
        if (!in_ready0) timeout("txn0_in_ready");
        in_valid0 = 1'b1; a0 = a; b0 = b; in_cin0 = c; out_ready0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom); in_cin0 = 1'($urandom);
        lat = 0;
        while (!out_valid0 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        if (!out_valid0) timeout("txn0_out_valid");
        s = out_sum0; co = out_cout0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_sum", 32'(out_sum0), 32'(s));
            chk("hold_cout", 32'(out_cout0), 32'(co));
            chk("hold_valid", 32'(out_valid0), 32'd1);
            chk("hold_in_ready", 32'(in_ready0), 32'd0);
        end
        out_ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready0 = 1'b0;
        chk("post_hs_in_ready", 32'(in_ready0), 32'd1);
        chk("post_hs_out_valid", 32'(out_valid0), 32'd0);
    endtask

    task automatic txn1(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int stall, output logic [7:0] s, output logic co,
                        output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready1 && w < 50) begin @(negedge clk); w++; end
        if (!in_ready1) timeout("txn1_in_ready");
        in_valid1 = 1'b1; a1 = a; b1 = b; in_cin1 = c; out_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); in_cin1 = 1'($urandom);
        lat = 0;
        while (!out_valid1 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        if (!out_valid1) timeout("txn1_out_valid");
        s = out_sum1; co = out_cout1;
        repeat (stall) @(negedge clk);
        chk("hold8_result", {23'd0, out_cout1, out_sum1}, {23'd0, co, s});
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic        co;
        int          lat;
        logic [16:0] exp17;
        logic [8:0]  exp9;
        logic [7:0]  s8;
        int          acc[2];
        logic [15:0] rs[2];
        logic        rc[2];
        int          n_acc, n_res;
        bit          pend, seen;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 10};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 2};
        tbl[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 0};
        tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 3};

        rst_n = 1'b0;
        in_valid0 = 1'b1; a0 = 16'hDEAD; b0 = 16'hBEEF; in_cin0 = 1'b1; out_ready0 = 1'b0;
        in_valid1 = 1'b1; a1 = 8'h5A;    b1 = 8'hA5;    in_cin1 = 1'b1; out_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_sum", 32'(out_sum0), 32'h0);
        chk("rst_out_cout", 32'(out_cout0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready0), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid0), 32'd0);

        for (int i = 0; i < 7; i++) begin
            txn0(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].stall, s, co, lat);
            chk($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(co), 32'(tbl[i].cout));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // Back-to-back with out_ready held high: accepts must be 6 cycles apart.
        @(negedge clk);
        out_ready0 = 1'b1; in_valid0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF; in_cin0 = 1'b1;
        n_acc = 0; n_res = 0; pend = 0;
        rs[0] = 'x; rs[1] = 'x; rc[0] = 1'bx; rc[1] = 1'bx; acc[0] = 0; acc[1] = 0;
        for (int i = 0; i < 40 && n_res < 2; i++) begin
            if (out_valid0) begin rs[n_res] = out_sum0; rc[n_res] = out_cout0; n_res++; end
            if (in_valid0 && in_ready0 && n_acc < 2) begin
                acc[n_acc] = cyc; n_acc++; pend = 1;
            end else if (pend) begin
                if (n_acc == 1) begin a0 = 16'h0000; b0 = 16'h0000; in_cin0 = 1'b0; end
                else in_valid0 = 1'b0;
                pend = 0;
            end
            @(negedge clk);
        end
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd2);
        chk("b2b_results", 32'(n_res), 32'd2);
        chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd6);
        chk("b2b_first", {15'd0, rc[0], rs[0]}, 32'h1FFFF);
        chk("b2b_second", {15'd0, rc[1], rs[1]}, 32'h00000);

        // Reset in the middle of RUN cycle 2 discards the operation.
        @(negedge clk);
        in_valid0 = 1'b1; a0 = 16'hABCD; b0 = 16'h1111; in_cin0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid0), 32'd0);
        chk("midrst_out_sum", 32'(out_sum0), 32'h0);
        chk("midrst_out_cout", 32'(out_cout0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready0), 32'd1);
        seen = 0;
        repeat (8) begin @(negedge clk); if (out_valid0 || busy0) seen = 1; end
        chk("midrst_no_output", 32'(seen), 32'd0);
        txn0(16'h0001, 16'h0002, 1'b0, 0, s, co, lat);
        chk("midrst_next", {15'd0, co, s}, 32'h00003);

        for (int i = 0; i < 500; i++) begin
            logic [15:0] ra, rb;
            logic        rcin;
            ra = (i % 16 == 0) ? 16'hFFFF : 16'($urandom);
            rb = 16'($urandom);
            rcin = 1'($urandom);
            exp17 = 17'(ra) + 17'(rb) + 17'(rcin);
            txn0(ra, rb, rcin, int'($urandom_range(0, 3)), s, co, lat);
            chk("rand16_result", {15'd0, co, s}, 32'(exp17));
            chk("rand16_latency", 32'(lat), 32'd4);
        end

        for (int i = 0; i < 100; i++) begin
            logic [7:0] ra, rb;
            logic       rcin;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rcin = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rcin);
            txn1(ra, rb, rcin, int'($urandom_range(0, 3)), s8, co, lat);
            chk("rand8_result", {23'd0, co, s8}, 32'(exp9));
            chk("rand8_latency", 32'(lat), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
